// File: rtl/latch_input_conditioner_pkg.sv
// Shared state encoding and default timing constants for the latch input conditioner.
package latch_input_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_EN_PULSE_CYCLES = 4;

endpackage

// File: rtl/latch_input_conditioner_debouncer.sv
// Two-flop synchronizer followed by a stability counter; the output only moves after
// the synchronized input has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
module debouncer
    import latch_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             out_q;
    logic             out_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Flip on the edge where the counter would reach DEBOUNCE_CYCLES, so it never wraps.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        if (sync2_q != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/latch_input_conditioner.sv
// Conditions a raw data switch and enable button into a clean setup/pulse/hold
// write sequence for a downstream D latch.
module latch_input_conditioner
    import latch_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int EN_PULSE_CYCLES = DEFAULT_EN_PULSE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_raw,
    input  logic en_raw,
    output logic d,
    output logic en,
    output logic busy
);

    localparam int PCNT_W = $clog2(EN_PULSE_CYCLES + 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(EN_PULSE_CYCLES - 1);

    logic              deb_data;
    logic              deb_en;
    logic              trigger;
    state_e            state_q;
    state_e            state_d;
    logic              en_prev_q;
    logic              hold_q;
    logic              hold_d;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;
    logic              en_q;
    logic              en_d;
    logic              busy_q;
    logic              busy_d;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_data (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (d_raw),
        .out  (deb_data)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_en (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (en_raw),
        .out  (deb_en)
    );

    // en_prev_q tracks even while busy, so a press held through a sequence cannot retrigger.
    assign trigger = (state_q == IDLE) && deb_en && !en_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            en_prev_q <= 1'b0;
            hold_q    <= 1'b0;
            pcnt_q    <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= deb_en;
            hold_q    <= hold_d;
            pcnt_q    <= pcnt_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pcnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = SETUP;
                    hold_d  = deb_data;
                end
            end
            SETUP: state_d = PULSE;
            PULSE: begin
                if (pcnt_q == PCNT_LAST) begin
                    state_d = HOLD;
                end else begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so en and busy come straight off flops.
    always_comb begin
        en_d   = (state_d == PULSE);
        busy_d = (state_d != IDLE);
    end

    assign d    = busy_q ? hold_q : deb_data;
    assign en   = en_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_latch_input_conditioner.sv
// Scenario bench for latch_input_conditioner with a cycle-level reference model.
module tb_latch_input_conditioner;

    localparam int DC  = 4;
    localparam int EPC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d_raw = 1'b0;
    logic en_raw = 1'b0;
    logic d;
    logic en;
    logic busy;

    int tests = 0;
    int fails = 0;

    bit histD [DC+2];
    bit histE [DC+2];
    bit debD, debE, prevDebE, cap;
    int pos;
    bit expD, expEn, expBusy;

    latch_input_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .EN_PULSE_CYCLES(EPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d_raw (d_raw),
        .en_raw(en_raw),
        .d     (d),
        .en    (en),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Raw history window: a value flips once the last DC synchronized samples all disagree.
    function automatic bit windowFlips(input bit h [DC+2], input bit v);
        bit all = 1'b1;
        for (int i = 1; i <= DC; i++) if (h[i] == v) all = 1'b0;
        return all;
    endfunction

    function void modelEdge(input bit rn, input bit dr, input bit er);
        bit trig;
        if (!rn) begin
            for (int i = 0; i < DC + 2; i++) begin
                histD[i] = 1'b0;
                histE[i] = 1'b0;
            end
            debD = 0; debE = 0; prevDebE = 0; cap = 0; pos = 0;
        end else begin
            trig = (pos == 0) && debE && !prevDebE;
            if (trig) begin
                cap = debD;
                pos = 1;
            end else if (pos == EPC + 2) begin
                pos = 0;
            end else if (pos != 0) begin
                pos++;
            end
            prevDebE = debE;
            if (windowFlips(histD, debD)) debD = !debD;
            if (windowFlips(histE, debE)) debE = !debE;
            for (int i = 0; i < DC + 1; i++) begin
                histD[i] = histD[i+1];
                histE[i] = histE[i+1];
            end
            histD[DC+1] = dr;
            histE[DC+1] = er;
        end
        expBusy = (pos != 0);
        expEn   = (pos >= 2) && (pos <= EPC + 1);
        expD    = expBusy ? cap : debD;
    endfunction

    task automatic tick(input bit rn, input bit dr, input bit er);
        rst_n  = rn;
        d_raw  = dr;
        en_raw = er;
        @(posedge clk);
        modelEdge(rn, dr, er);
        #1;
    endtask

    task automatic settle(input bit dr, input bit er, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, dr, er);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tests++;
            if ({d, en, busy} !== 3'b000) begin
                fails++;
                $display("[TB] FAIL reset_outputs cycle %0d: got d/en/busy=%b%b%b want 000", i, d, en, busy);
            end
        end
        settle(1'b0, 1'b0, 10);
    endtask

    task automatic test_debounce();
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            tests++;
            if (d !== ((i == 6) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("[TB] FAIL debounce_rise edge %0d: got d=%b want %b", i, d, (i == 6));
            end
        end
        settle(1'b0, 1'b0, 10);
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, (i < 3) ? 1'b1 : 1'b0, 1'b0);
            tests++;
            if (d !== 1'b0) begin
                fails++;
                $display("[TB] FAIL debounce_glitch cycle %0d: got d=%b want 0", i, d);
            end
        end
    endtask

    task automatic test_full_sequence();
        bit expEnSeq [6] = '{0, 1, 1, 1, 0, 0};
        bit expBusySeq [6] = '{1, 1, 1, 1, 1, 0};
        int n;
        settle(1'b1, 1'b0, 10);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b1, 1'b1);
            if (busy === 1'b1) begin
                n = i;
                break;
            end
        end
        tests++;
        if (n != 7) begin
            fails++;
            $display("[TB] FAIL seq_latency: busy rose after %0d edges want 7", n);
        end
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (en !== expEnSeq[k] || busy !== expBusySeq[k] || d !== 1'b1) begin
                fails++;
                $display("[TB] FAIL seq_shape step %0d: got en/busy/d=%b%b%b want %b%b1",
                         k, en, busy, d, expEnSeq[k], expBusySeq[k]);
            end
            tick(1'b1, 1'b1, 1'b1);
        end
        settle(1'b1, 1'b0, 10);
    endtask

    task automatic test_data_stability();
        int guard;
        settle(1'b0, 1'b0, 10);
        guard = 0;
        while (busy !== 1'b1 && guard < 20) begin
            tick(1'b1, 1'b0, 1'b1);
            guard++;
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stab_start: got busy=%b want 1", busy);
        end
        guard = 0;
        while (busy === 1'b1 && guard < 10) begin
            tests++;
            if (d !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stab_hold cycle %0d: got d=%b want 0", guard, d);
            end
            tick(1'b1, guard[0] ? 1'b0 : 1'b1, 1'b0);
            guard++;
        end
        settle(1'b1, 1'b0, 8);
        tests++;
        if (d !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stab_follow: got d=%b want 1", d);
        end
        settle(1'b0, 1'b0, 10);
    endtask

    task automatic test_same_edge();
        int guard;
        tick(1'b1, 1'b0, 1'b1);
        guard = 0;
        while (busy !== 1'b1 && guard < 20) begin
            tick(1'b1, 1'b1, 1'b1);
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (busy !== 1'b1 || d !== 1'b0) begin
                fails++;
                $display("[TB] FAIL same_edge_capture step %0d: got busy/d=%b%b want 10", k, busy, d);
            end
            tick(1'b1, 1'b1, 1'b0);
        end
        tests++;
        if (busy !== 1'b0 || d !== 1'b1) begin
            fails++;
            $display("[TB] FAIL same_edge_release: got busy/d=%b%b want 01", busy, d);
        end
        settle(1'b1, 1'b0, 10);
    endtask

    task automatic test_back_to_back();
        int pulses;
        bit lastEn;
        pulses = 0;
        lastEn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b1, 1'b1);
            if (en && !lastEn) pulses++;
            lastEn = en;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("[TB] FAIL retrigger_held: got %0d pulses want 1", pulses);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b1, (i >= 10) ? 1'b1 : 1'b0);
            if (en && !lastEn) pulses++;
            lastEn = en;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("[TB] FAIL retrigger_repress: got %0d pulses want 1", pulses);
        end
        settle(1'b1, 1'b0, 10);
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (en !== 1'b1 && guard < 20) begin
            tick(1'b1, 1'b1, 1'b1);
            guard++;
        end
        tests++;
        if (en !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_pulse: got en=%b want 1", en);
        end
        tick(1'b0, 1'b1, 1'b0);
        tests++;
        if ({d, en, busy} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL midrst_drop: got d/en/busy=%b%b%b want 000", d, en, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            tests++;
            if (busy !== 1'b0 || en !== 1'b0) begin
                fails++;
                $display("[TB] FAIL midrst_idle cycle %0d: got en/busy=%b%b want 00", i, en, busy);
            end
        end
        settle(1'b0, 1'b0, 10);
    endtask

    task automatic test_random();
        bit dr, er, rn;
        dr = 1'b0;
        er = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) dr = !dr;
            if ($urandom_range(0, 6) == 0) er = !er;
            rn = ($urandom_range(0, 249) != 0);
            tick(rn, dr, er);
            tests++;
            if ({d, en, busy} !== {expD, expEn, expBusy}) begin
                fails++;
                $display("[TB] FAIL random cycle %0d: got d/en/busy=%b%b%b want %b%b%b",
                         i, d, en, busy, expD, expEn, expBusy);
            end
        end
    endtask

    initial begin
        modelEdge(1'b0, 1'b0, 1'b0);
        test_reset();
        test_debounce();
        test_full_sequence();
        test_data_stability();
        test_same_edge();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
